multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
State-machine sequencer for the multicycle MIPS datapath, replacing per-instruction single-cycle decode with per-state control words. Sits beside the shared datapath (PC, IR, register file, ALU, unified memory) and steps each instruction through fetch, decode, execute, memory and writeback. Handles a memory ready handshake and a memory watchdog. Traps on illegal opcodes.

Parameters:
MEM_TIMEOUT, 255, max cycles a memory state waits for mem_ready before trapping; 0 disables the watchdog.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26]; IR is stable from DECODE until the next FETCH
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request
iord  output  1  0 = instruction address (PC), 1 = data address (ALUOut)
mem_wr  output  1  memory write
ir_wr  output  1  IR load
pc_en  output  1  PC load = pc_wr OR (branch AND zero)
reg_dst  output  1  1 = rd, 0 = rt
mem_to_reg  output  1  1 = memory data, 0 = ALUOut
reg_wr  output  1  register file write
alu_src_a  output  1  0 = PC, 1 = rs
alu_src_b  output  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
alu_op  output  2  00 = add, 01 = sub, 10 = funct
pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_op  output  1  sticky trap flag
mem_timeout  output  1  sticky watchdog flag
state_o  output  4  current state, debug

Behaviour:
- Reset (async, rst_n=0): state = FETCH, watchdog counter = 0. While rst_n=0, all strobes are forced to 0: mem_req, mem_wr, ir_wr, pc_en, reg_wr. illegal_op = 0, mem_timeout = 0. Other outputs take FETCH values.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, TRAP 12. Codes 13-15 go to TRAP.
- Outputs are Moore from state. Exception: ir_wr and pc_wr in FETCH are qualified by mem_ready. Unlisted outputs are 0.
- FETCH
  - Controls: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - On mem_ready: ir_wr=1, pc_wr=1, next state DECODE. Otherwise hold.
- DECODE
  - Controls: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by opcode: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; any other -> TRAP.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_wr=1. Next FETCH.
- MEMWR: mem_req=1, mem_wr=1, iord=1. Hold until mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next ALUWB.
- ALUWB: reg_dst=1, reg_wr=1. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1. pc_en = zero. Next FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDIWB.
- ADDIWB: reg_dst=0, reg_wr=1. Next FETCH.
- JUMP: pc_src=10, pc_wr=1. Next FETCH.
- TRAP: all strobes 0. Held until reset. illegal_op is set on entry from DECODE or from an invalid state code.
- Watchdog
  - Counter clears on entry to FETCH, MEMRD or MEMWR, and whenever mem_ready=1.
  - It increments each cycle spent waiting in those states.
  - When the counter reaches MEM_TIMEOUT without mem_ready, the FSM enters TRAP and sets mem_timeout.
  - mem_ready on the timeout cycle wins: normal transition, no trap.
- Latency (zero-wait memory): R-type/addi 4 cycles, lw 5, sw 4, beq 3, j 3. Each memory wait cycle adds 1.

Optional Feature:
MC_INSTR_COUNT_EN
- Defined: adds output instr_count [31:0], reset 0. It increments by 1 on each retire: leaving MEMWB, ALUWB, ADDIWB, BRANCH or JUMP, or MEMWR with mem_ready. Wraps modulo 2^32; not incremented in TRAP.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package mc_pkg holds:
  - state localparams (4-bit);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - alu_op codes, alu_src_b codes and pc_src codes.
- One sub-module, mc_state_decoder: purely combinational map from state to the Moore control word. The top holds the state register, next-state logic, watchdog, mem_ready qualification and pc_en.

Test Plan:
- Reset: rst_n=0 mid-DECODE -> state_o=0, strobes 0, flags 0. Release with mem_ready=1 -> ir_wr=pc_en=1 in the first cycle.
- lw 0x8C..., mem_ready low 2 cycles in MEMRD -> state path 0,1,2,3,3,3,4,0; reg_wr=1 and mem_to_reg=1 only in state 4; 7 cycles total.
- R-type (opcode 0) -> EXEC with alu_op=10, then ALUWB with reg_dst=1, reg_wr=1; back to FETCH after 4 cycles.
- beq with zero=1 -> pc_en=1 and pc_src=01 in BRANCH; repeat with zero=0 -> pc_en=0.
- Opcode 0x3F -> TRAP after DECODE, illegal_op=1; mem_ready toggling leaves it stuck until rst_n pulse.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 wait cycles, mem_timeout=1. With MC_INSTR_COUNT_EN, 3 addi instructions -> instr_count=3.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS controller: state codes, opcodes,
// datapath select encodings and the Moore control word.
package mc_pkg;

    localparam logic [3:0] StFetch  = 4'd0;
    localparam logic [3:0] StDecode = 4'd1;
    localparam logic [3:0] StMemAdr = 4'd2;
    localparam logic [3:0] StMemRd  = 4'd3;
    localparam logic [3:0] StMemWb  = 4'd4;
    localparam logic [3:0] StMemWr  = 4'd5;
    localparam logic [3:0] StExec   = 4'd6;
    localparam logic [3:0] StAluWb  = 4'd7;
    localparam logic [3:0] StBranch = 4'd8;
    localparam logic [3:0] StAddiEx = 4'd9;
    localparam logic [3:0] StAddiWb = 4'd10;
    localparam logic [3:0] StJump   = 4'd11;
    localparam logic [3:0] StTrap   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    localparam logic [1:0] SrcBRt    = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_wr;
        logic       ir_wr;
        logic       pc_wr;
        logic       branch;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_wr;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    function automatic logic is_mem_wait_state(input logic [3:0] st);
        return (st == StFetch) || (st == StMemRd) || (st == StMemWr);
    endfunction

endpackage

// File: rtl/mc_state_decoder.sv
// Combinational map from controller state to the unqualified Moore control word.
module mc_state_decoder
    import mc_pkg::*;
(
    input  logic [3:0] state_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            StFetch: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.ir_wr     = 1'b1;
                ctrl_o.pc_wr     = 1'b1;
                ctrl_o.alu_src_b = SrcBFour;
                ctrl_o.alu_op    = AluAdd;
                ctrl_o.pc_src    = PcSrcAlu;
            end
            StDecode: begin
                ctrl_o.alu_src_b = SrcBImmSh;
                ctrl_o.alu_op    = AluAdd;
            end
            StMemAdr, StAddiEx: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBImm;
                ctrl_o.alu_op    = AluAdd;
            end
            StMemRd: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            StMemWb: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_wr     = 1'b1;
            end
            StMemWr: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.mem_wr  = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            StExec: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBRt;
                ctrl_o.alu_op    = AluFunct;
            end
            StAluWb: begin
                ctrl_o.reg_dst = 1'b1;
                ctrl_o.reg_wr  = 1'b1;
            end
            StBranch: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SrcBRt;
                ctrl_o.alu_op    = AluSub;
                ctrl_o.pc_src    = PcSrcAluOut;
                ctrl_o.branch    = 1'b1;
            end
            StAddiWb: begin
                ctrl_o.reg_wr = 1'b1;
            end
            StJump: begin
                ctrl_o.pc_src = PcSrcJump;
                ctrl_o.pc_wr  = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM with memory ready handshake, watchdog and illegal-op trap.
// Optional retired-instruction counter enabled by defining MC_INSTR_COUNT_EN.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       mem_wr,
    output logic       ir_wr,
    output logic       pc_en,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_wr,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic       mem_timeout,
`ifdef MC_INSTR_COUNT_EN
    output logic [31:0] instr_count,
`endif
    output logic [3:0] state_o
);

    logic [3:0]  state_q, state_d;
    logic [31:0] wd_q, wd_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;
    logic        wd_trip;
    logic [3:0]  done_st;
    ctrl_t       ctrl;

    mc_state_decoder u_decoder (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            wd_q      <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Trips on the wait cycle whose increment would make the counter reach MEM_TIMEOUT.
    assign wd_trip = (MEM_TIMEOUT != 0) && (wd_q == 32'(MEM_TIMEOUT - 1));

    assign done_st = (state_q == StFetch) ? StDecode :
                     (state_q == StMemRd) ? StMemWb  : StFetch;

    always_comb begin
        state_d   = state_q;
        wd_d      = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            StFetch, StMemRd, StMemWr: begin
                if (mem_ready) begin
                    state_d = done_st;
                end else if (wd_trip) begin
                    state_d   = StTrap;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
            end
            StDecode: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExec;
                    OP_BEQ:       state_d = StBranch;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_J:         state_d = StJump;
                    default: begin
                        state_d   = StTrap;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAdr: state_d = (opcode == OP_SW) ? StMemWr : StMemRd;
            StExec:   state_d = StAluWb;
            StAddiEx: state_d = StAddiWb;
            StMemWb, StAluWb, StAddiWb, StBranch, StJump: state_d = StFetch;
            StTrap:   state_d = StTrap;
            default: begin
                state_d   = StTrap;
                illegal_d = 1'b1;
            end
        endcase
        // Counter only carries across cycles spent waiting in a memory state.
        if (!is_mem_wait_state(state_d) || state_d != state_q) begin
            wd_d = '0;
        end
    end

    // Strobes are gated by rst_n so nothing fires while reset is held.
    always_comb begin
        mem_req     = rst_n & ctrl.mem_req;
        iord        = ctrl.iord;
        mem_wr      = rst_n & ctrl.mem_wr;
        ir_wr       = rst_n & ctrl.ir_wr & mem_ready;
        pc_en       = rst_n & ((ctrl.pc_wr & ((state_q != StFetch) | mem_ready)) |
                               (ctrl.branch & zero));
        reg_dst     = ctrl.reg_dst;
        mem_to_reg  = ctrl.mem_to_reg;
        reg_wr      = rst_n & ctrl.reg_wr;
        alu_src_a   = ctrl.alu_src_a;
        alu_src_b   = ctrl.alu_src_b;
        alu_op      = ctrl.alu_op;
        pc_src      = ctrl.pc_src;
        illegal_op  = illegal_q;
        mem_timeout = timeout_q;
        state_o     = state_q;
    end

`ifdef MC_INSTR_COUNT_EN
    logic [31:0] count_q, count_d;
    logic        retire;

    always_comb begin
        retire = (state_q == StMemWb) || (state_q == StAluWb) || (state_q == StAddiWb) ||
                 (state_q == StBranch) || (state_q == StJump) ||
                 ((state_q == StMemWr) && mem_ready);
        count_d = retire ? count_q + 32'd1 : count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller (watchdog set to 4 cycles).
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, iord, mem_wr, ir_wr, pc_en, reg_dst, mem_to_reg, reg_wr, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       illegal_op, mem_timeout;
    logic [3:0] state_o;
`ifdef MC_INSTR_COUNT_EN
    logic [31:0] instr_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [20:0] v;
    } exp_t;

    exp_t sb_q[$];
    logic [20:0] obs;

    multicycle_controller #(.MEM_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .iord        (iord),
        .mem_wr      (mem_wr),
        .ir_wr       (ir_wr),
        .pc_en       (pc_en),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_wr      (reg_wr),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .pc_src      (pc_src),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout),
`ifdef MC_INSTR_COUNT_EN
        .instr_count (instr_count),
`endif
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    assign obs = {state_o, illegal_op, mem_timeout, mem_req, iord, mem_wr, ir_wr, pc_en,
                  reg_dst, mem_to_reg, reg_wr, alu_src_a, alu_src_b, alu_op, pc_src};

    // Expected control word straight from the per-state control table.
    function automatic logic [14:0] model(input logic [3:0] st, input logic rn,
                                          input logic rdy, input logic zr);
        logic       mreq, io, mwr, irw, pce, rdst, m2r, rw, sa;
        logic [1:0] sbv, op, ps;
        {mreq, io, mwr, irw, pce, rdst, m2r, rw, sa} = '0;
        sbv = 2'b00;
        op  = 2'b00;
        ps  = 2'b00;
        case (st)
            4'd0:  begin mreq = 1; irw = rdy; pce = rdy; sbv = 2'b01; end
            4'd1:  sbv = 2'b11;
            4'd2:  begin sa = 1; sbv = 2'b10; end
            4'd3:  begin mreq = 1; io = 1; end
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin mreq = 1; mwr = 1; io = 1; end
            4'd6:  begin sa = 1; op = 2'b10; end
            4'd7:  begin rdst = 1; rw = 1; end
            4'd8:  begin sa = 1; op = 2'b01; ps = 2'b01; pce = zr; end
            4'd9:  begin sa = 1; sbv = 2'b10; end
            4'd10: rw = 1;
            4'd11: begin ps = 2'b10; pce = 1; end
            default: ;
        endcase
        if (!rn) begin
            mreq = 0; mwr = 0; irw = 0; pce = 0; rw = 0;
        end
        return {mreq, io, mwr, irw, pce, rdst, m2r, rw, sa, sbv, op, ps};
    endfunction

    task automatic step(input string tag, input logic [5:0] op, input logic zr,
                        input logic rdy, input logic [3:0] st, input logic ill,
                        input logic to);
        exp_t e;
        opcode    = op;
        zero      = zr;
        mem_ready = rdy;
        e.tag = tag;
        e.v   = {st, ill, to, model(st, rst_n, rdy, zr)};
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        vectors++;
        assert (obs === e.v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] exp_cnt);
`ifdef MC_INSTR_COUNT_EN
        vectors++;
        assert (instr_count === exp_cnt) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, instr_count, exp_cnt);
        end
`else
        if (tag.len() == 0 && exp_cnt != 0) $display("count check skipped");
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: observed no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        #2 rst_n = 1'b0;
        step("rst_hold", 6'h00, 0, 0, 4'd0, 0, 0);
        rst_n = 1'b1;
        step("fetch0", 6'h23, 0, 1, 4'd0, 0, 0);
        // Now in DECODE: assert reset mid-state
        rst_n = 1'b0;
        step("rst_mid_decode", 6'h23, 0, 1, 4'd0, 0, 0);
        check_cnt("cnt_reset", 32'd0);
        rst_n = 1'b1;
        step("rel_fetch", 6'h23, 0, 1, 4'd0, 0, 0);

        step("lw_dec", 6'h23, 0, 0, 4'd1, 0, 0);
        step("lw_adr", 6'h23, 0, 0, 4'd2, 0, 0);
        step("lw_rd_w1", 6'h23, 0, 0, 4'd3, 0, 0);
        step("lw_rd_w2", 6'h23, 0, 0, 4'd3, 0, 0);
        step("lw_rd_ok", 6'h23, 0, 1, 4'd3, 0, 0);
        step("lw_wb", 6'h23, 0, 0, 4'd4, 0, 0);

        step("r_fetch", 6'h00, 0, 1, 4'd0, 0, 0);
        step("r_dec", 6'h00, 0, 0, 4'd1, 0, 0);
        step("r_exec", 6'h00, 0, 0, 4'd6, 0, 0);
        step("r_wb", 6'h00, 0, 0, 4'd7, 0, 0);

        step("beq_fetch", 6'h04, 0, 1, 4'd0, 0, 0);
        step("beq_dec", 6'h04, 0, 0, 4'd1, 0, 0);
        step("beq_taken", 6'h04, 1, 0, 4'd8, 0, 0);
        step("beq2_fetch", 6'h04, 0, 1, 4'd0, 0, 0);
        step("beq2_dec", 6'h04, 0, 0, 4'd1, 0, 0);
        step("beq_not", 6'h04, 0, 0, 4'd8, 0, 0);

        for (int i = 0; i < 3; i++) begin
            step("addi_fetch", 6'h08, 0, 1, 4'd0, 0, 0);
            step("addi_dec", 6'h08, 0, 0, 4'd1, 0, 0);
            step("addi_ex", 6'h08, 0, 0, 4'd9, 0, 0);
            step("addi_wb", 6'h08, 0, 0, 4'd10, 0, 0);
        end
        check_cnt("cnt_after_addi", 32'd7);

        step("j_fetch", 6'h02, 0, 1, 4'd0, 0, 0);
        step("j_dec", 6'h02, 0, 0, 4'd1, 0, 0);
        step("j_jump", 6'h02, 0, 0, 4'd11, 0, 0);

        step("sw_fetch", 6'h2B, 0, 1, 4'd0, 0, 0);
        step("sw_dec", 6'h2B, 0, 0, 4'd1, 0, 0);
        step("sw_adr", 6'h2B, 0, 0, 4'd2, 0, 0);
        step("sw_wr_wait", 6'h2B, 0, 0, 4'd5, 0, 0);
        step("sw_wr_ok", 6'h2B, 0, 1, 4'd5, 0, 0);
        check_cnt("cnt_after_sw", 32'd9);

        step("ill_fetch", 6'h3F, 0, 1, 4'd0, 0, 0);
        step("ill_dec", 6'h3F, 0, 0, 4'd1, 0, 0);
        step("ill_trap1", 6'h3F, 0, 1, 4'd12, 1, 0);
        step("ill_trap2", 6'h3F, 0, 0, 4'd12, 1, 0);
        step("ill_trap3", 6'h3F, 1, 1, 4'd12, 1, 0);
        check_cnt("cnt_in_trap", 32'd9);
        rst_n = 1'b0;
        step("trap_rst", 6'h00, 0, 0, 4'd0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            step("to_wait", 6'h00, 0, 0, 4'd0, 0, 0);
        end
        step("to_trap", 6'h00, 0, 1, 4'd12, 0, 1);
        step("to_stuck", 6'h00, 0, 0, 4'd12, 0, 1);
        rst_n = 1'b0;
        step("to_rst", 6'h00, 0, 0, 4'd0, 0, 0);
        rst_n = 1'b1;

        // Ready on the would-be timeout cycle wins over the trap.
        for (int i = 0; i < 3; i++) begin
            step("race_wait", 6'h00, 0, 0, 4'd0, 0, 0);
        end
        step("race_ready", 6'h00, 0, 1, 4'd0, 0, 0);
        step("race_dec", 6'h00, 0, 0, 4'd1, 0, 0);
        step("race_exec", 6'h00, 0, 0, 4'd6, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
